// File: rtl/ili9341_spi_tx_pkg.sv
// Shared types and constants for the ILI9341 SPI byte transmitter.
// Pin levels, the FSM state encoding and the default transfer geometry live here.
package ili9341_spi_tx_pkg;

  localparam logic       LOW     = 1'b0;
  localparam logic       HIGH    = 1'b1;
  localparam logic [7:0] NO_DATA = 8'h00;

  localparam int SPI_DW      = 8;
  localparam int SPI_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    DONE,
    REARM
  } spi_tx_state_t;

  // The SCK phase divider only runs while a byte is actually on the wire.
  function automatic logic phase_active(input spi_tx_state_t s);
    return s inside {SETUP, SHIFT_HI, SHIFT_LO};
  endfunction

endpackage

// File: rtl/ili9341_spi_tx_if.sv
// Request/acknowledge handshake between the command sequencer (master)
// and the SPI byte transmitter (slave).
interface ili9341_spi_tx_if #(
  parameter int DW = 8
) ();

  logic          i_send;
  logic [DW-1:0] i_data;
  logic          i_dc;
  logic          i_cs;
  logic          o_command_sent;
  logic          o_busy;

  modport master (
    output i_send, i_data, i_dc, i_cs,
    input  o_command_sent, o_busy
  );

  modport slave (
    input  i_send, i_data, i_dc, i_cs,
    output o_command_sent, o_busy
  );

endinterface

// File: rtl/ili9341_spi_tx_clk_phase.sv
// SCK phase timer: counts CLK_DIV system clocks per phase and strobes
// phase_end during the last clock of each phase.
module spi_clk_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic phase_end
);

  localparam int            CW     = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == '0);

  // Reloading on every phase end keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || phase_end) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ili9341_spi_tx.sv
// SPI mode-0 byte transmitter for the ILI9341 panel: latches one byte per
// request, shifts it MSB-first, drives D/C and CS, then pulses command_sent.
module ili9341_spi_tx
  import ili9341_spi_tx_pkg::*;
#(
  parameter int DW      = SPI_DW,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  ili9341_spi_tx_if.slave      bus,
  output logic                 o_sck,
  output logic                 o_mosi,
  output logic                 o_dc,
  output logic                 o_cs
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  spi_tx_state_t  state;
  logic [DW-1:0]  shreg;
  logic [BW-1:0]  bit_cnt;
  logic           cs_q;
  logic           phase_end;
  logic           phase_en;
  logic           accept;

  assign phase_en = phase_active(state);
  assign accept   = (state == IDLE) && bus.i_send;

  spi_clk_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .en        (phase_en),
    .load      (accept),
    .phase_end (phase_end)
  );

  // NOTE: every register here is assigned with <= so all pins update together
  // from values sampled before the edge; blocking '=' would let later lines
  // see half-updated state and simulate differently from the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      shreg              <= DW'(NO_DATA);
      bit_cnt            <= '0;
      cs_q               <= HIGH;
      o_sck              <= LOW;
      o_mosi             <= LOW;
      o_dc               <= HIGH;
      o_cs               <= HIGH;
      bus.o_command_sent <= LOW;
      bus.o_busy         <= LOW;
    end else begin
      bus.o_command_sent <= LOW;
      case (state)
        IDLE: begin
          if (bus.i_send) begin
            shreg      <= bus.i_data;
            cs_q       <= bus.i_cs;
            bit_cnt    <= BW'(DW - 1);
            o_cs       <= LOW;
            o_dc       <= bus.i_dc;
            o_mosi     <= bus.i_data[DW-1];
            o_sck      <= LOW;
            bus.o_busy <= HIGH;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (phase_end) begin
            o_sck <= HIGH;
            state <= SHIFT_HI;
          end
        end

        // Falling SCK edge: present the next bit a full phase before the rise.
        SHIFT_HI: begin
          if (phase_end) begin
            o_sck  <= LOW;
            shreg  <= {shreg[DW-2:0], 1'b0};
            o_mosi <= shreg[DW-2];
            state  <= SHIFT_LO;
          end
        end

        // The last low phase doubles as CS hold time before release.
        SHIFT_LO: begin
          if (phase_end) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - BW'(1);
              o_sck   <= HIGH;
              state   <= SHIFT_HI;
            end else begin
              bus.o_command_sent <= HIGH;
              o_cs               <= cs_q;
              o_mosi             <= LOW;
              state              <= DONE;
            end
          end
        end

        DONE: begin
          state <= REARM;
        end

        // A request still held from the previous byte must not retrigger it.
        REARM: begin
          if (!bus.i_send) begin
            bus.o_busy <= LOW;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Directed bench for ili9341_spi_tx: a default-divider instance and a
// CLK_DIV=1 instance, with a byte scoreboard fed by MOSI sampled on SCK rises.
module tb_ili9341_spi_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ili9341_spi_tx_if #(.DW(8)) bus_a ();
  ili9341_spi_tx_if #(.DW(8)) bus_b ();

  logic sck_a, mosi_a, dc_a, cs_a;
  logic sck_b, mosi_b, dc_b, cs_b;

  ili9341_spi_tx #(.DW(8), .CLK_DIV(4)) dut (
    .clk (clk), .rst (rst), .bus (bus_a),
    .o_sck (sck_a), .o_mosi (mosi_a), .o_dc (dc_a), .o_cs (cs_a)
  );

  ili9341_spi_tx #(.DW(8), .CLK_DIV(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus_b),
    .o_sck (sck_b), .o_mosi (mosi_b), .o_dc (dc_b), .o_cs (cs_b)
  );

  logic sck_v[2], mosi_v[2], dc_v[2], cs_v[2], sent_v[2], busy_v[2];
  assign sck_v[0]  = sck_a;              assign sck_v[1]  = sck_b;
  assign mosi_v[0] = mosi_a;             assign mosi_v[1] = mosi_b;
  assign dc_v[0]   = dc_a;               assign dc_v[1]   = dc_b;
  assign cs_v[0]   = cs_a;               assign cs_v[1]   = cs_b;
  assign sent_v[0] = bus_a.o_command_sent; assign sent_v[1] = bus_b.o_command_sent;
  assign busy_v[0] = bus_a.o_busy;       assign busy_v[1] = bus_b.o_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference SCK level in cycle k after acceptance for divider div.
  function automatic logic sck_model(input int k, input int div);
    if (k <= div) return 1'b0;
    return (((k - 1 - div) / div) % 2) == 0;
  endfunction

  // Per-instance monitor: assemble bytes from MOSI on SCK rises, count pulses.
  for (genvar g = 0; g < 2; g++) begin : mon
    int         bytes_rx = 0;
    int         pulses   = 0;
    int         nbits    = 0;
    logic [7:0] sh       = 8'h00;
    logic       prev_sck = 1'b0;
    exp_t       e;
    always @(negedge clk) begin
      if (rst) begin
        nbits    = 0;
        prev_sck = 1'b0;
      end else begin
        if (sck_v[g] && !prev_sck) begin
          sh = {sh[6:0], mosi_v[g]};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            bytes_rx++;
            if (exp_q.size() == 0) begin
              check("unexpected_byte", sh, 32'hdead);
            end else begin
              e = exp_q.pop_front();
              check("mosi_byte", sh, e.data);
              check("dc_at_byte", dc_v[g], e.dc);
            end
          end
        end
        prev_sck = sck_v[g];
        if (sent_v[g]) pulses++;
      end
    end
  end

  task automatic drive(input int which, input logic send, input logic [7:0] d,
                       input logic dc, input logic cs);
    if (which == 0) begin
      bus_a.i_send = send; bus_a.i_data = d; bus_a.i_dc = dc; bus_a.i_cs = cs;
    end else begin
      bus_b.i_send = send; bus_b.i_data = d; bus_b.i_dc = dc; bus_b.i_cs = cs;
    end
  endtask

  // One request held until the pulse (or glitched at cycle drop_at).
  task automatic xfer(input int which, input logic [7:0] d, input logic dc,
                      input logic cs, input int drop_at, input int div,
                      output int sent_at, output int cs_low, output int dc_bad,
                      output int sck_bad, output logic cs_end, output logic busy1);
    exp_q.push_back('{data: d, dc: dc});
    @(negedge clk);
    drive(which, 1'b1, d, dc, cs);
    sent_at = 0; cs_low = 0; dc_bad = 0; sck_bad = 0; cs_end = 1'bx; busy1 = 1'bx;
    for (int k = 1; k <= 40 * div + 20 && sent_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy_v[which];
      if (k == drop_at) drive(which, 1'b0, 8'h55, !dc, !cs);
      if (sent_v[which]) begin
        sent_at = k;
        cs_end  = cs_v[which];
      end else begin
        if (cs_v[which] == 1'b0) cs_low++;
        if (dc_v[which] !== dc) dc_bad++;
        if (sck_v[which] !== sck_model(k, div)) sck_bad++;
      end
    end
    drive(which, 1'b0, d, dc, cs);
  endtask

  initial begin
    int   sent_at, cs_low, dc_bad, sck_bad, p0, b0, gap_bad;
    logic cs_end, busy1;

    drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_sck", sck_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_cs", cs_a, 1'b1);
    check("rst_dc", dc_a, 1'b1);
    check("rst_sent", bus_a.o_command_sent, 1'b0);
    check("rst_busy", bus_a.o_busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single command 0x2A
    p0 = mon[0].pulses; b0 = mon[0].bytes_rx;
    xfer(0, 8'h2A, 1'b0, 1'b1, 0, 4, sent_at, cs_low, dc_bad, sck_bad, cs_end, busy1);
    check("t1_busy_cycle1", busy1, 1'b1);
    check("t1_sent_cycle", sent_at, 69);
    check("t1_cs_low_cycles", cs_low, 68);
    check("t1_dc_bad", dc_bad, 0);
    check("t1_sck_bad", sck_bad, 0);
    check("t1_cs_after", cs_end, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_busy_idle", bus_a.o_busy, 1'b0);
    check("t1_pulses", mon[0].pulses - p0, 1);
    check("t1_bytes", mon[0].bytes_rx - b0, 1);

    // Held request: one byte, one pulse, parked in REARM
    p0 = mon[0].pulses; b0 = mon[0].bytes_rx;
    exp_q.push_back('{data: 8'hFF, dc: 1'b1});
    @(negedge clk);
    drive(0, 1'b1, 8'hFF, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    check("held_pulses", mon[0].pulses - p0, 1);
    check("held_bytes", mon[0].bytes_rx - b0, 1);
    check("held_busy_rearm", bus_a.o_busy, 1'b1);
    drive(0, 1'b0, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    check("held_busy_release", bus_a.o_busy, 1'b0);

    // Back-to-back data bytes with CS kept low
    p0 = mon[0].pulses; b0 = mon[0].bytes_rx;
    xfer(0, 8'h00, 1'b1, 1'b0, 0, 4, sent_at, cs_low, dc_bad, sck_bad, cs_end, busy1);
    check("b2b0_sent_cycle", sent_at, 69);
    check("b2b0_dc_bad", dc_bad, 0);
    check("b2b0_cs_end", cs_end, 1'b0);
    gap_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cs_a !== 1'b0) gap_bad++;
    end
    check("b2b_cs_gap", gap_bad, 0);
    xfer(0, 8'h80, 1'b1, 1'b0, 0, 4, sent_at, cs_low, dc_bad, sck_bad, cs_end, busy1);
    check("b2b1_sent_cycle", sent_at, 69);
    check("b2b1_cs_low_cycles", cs_low, 68);
    check("b2b1_cs_end", cs_end, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_pulses", mon[0].pulses - p0, 2);
    check("b2b_bytes", mon[0].bytes_rx - b0, 2);

    // Input glitch: data, dc, cs and send all change at cycle 10
    p0 = mon[0].pulses;
    xfer(0, 8'hC3, 1'b0, 1'b1, 10, 4, sent_at, cs_low, dc_bad, sck_bad, cs_end, busy1);
    check("glitch_sent_cycle", sent_at, 69);
    check("glitch_dc_bad", dc_bad, 0);
    check("glitch_cs_end", cs_end, 1'b1);
    repeat (2) @(negedge clk);
    check("glitch_pulses", mon[0].pulses - p0, 1);

    // Reset during SHIFT_HI of bit 4 (cycles 29..32)
    p0 = mon[0].pulses;
    @(negedge clk);
    drive(0, 1'b1, 8'h5A, 1'b1, 1'b1);
    repeat (29) @(negedge clk);
    check("mid_sck_hi", sck_a, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 8'h5A, 1'b1, 1'b1);
    #1;
    check("mid_rst_sck", sck_a, 1'b0);
    check("mid_rst_mosi", mosi_a, 1'b0);
    check("mid_rst_cs", cs_a, 1'b1);
    check("mid_rst_dc", dc_a, 1'b1);
    check("mid_rst_sent", bus_a.o_command_sent, 1'b0);
    check("mid_rst_busy", bus_a.o_busy, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_pulse", mon[0].pulses - p0, 0);
    rst = 1'b0;
    b0 = mon[0].bytes_rx;
    xfer(0, 8'h5A, 1'b1, 1'b1, 0, 4, sent_at, cs_low, dc_bad, sck_bad, cs_end, busy1);
    check("post_rst_sent_cycle", sent_at, 69);
    check("post_rst_sck_bad", sck_bad, 0);
    repeat (2) @(negedge clk);
    check("post_rst_bytes", mon[0].bytes_rx - b0, 1);

    // CLK_DIV=1 instance
    p0 = mon[1].pulses; b0 = mon[1].bytes_rx;
    xfer(1, 8'hA5, 1'b1, 1'b1, 0, 1, sent_at, cs_low, dc_bad, sck_bad, cs_end, busy1);
    check("div1_sent_cycle", sent_at, 18);
    check("div1_cs_low_cycles", cs_low, 17);
    check("div1_sck_bad", sck_bad, 0);
    check("div1_cs_end", cs_end, 1'b1);
    repeat (2) @(negedge clk);
    check("div1_busy_idle", bus_b.o_busy, 1'b0);
    check("div1_pulses", mon[1].pulses - p0, 1);
    check("div1_bytes", mon[1].bytes_rx - b0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ili9341_spi_tx.md
# ili9341_spi_tx

SPI byte transmitter for the ILI9341 panel, consuming the send/data/dc/cs handshake produced by the command sequencer. It latches one byte per request and shifts it MSB-first onto the panel pins in SPI mode 0. It drives D/C and CS for the byte, then returns a one-cycle `o_command_sent` pulse. It sits between the sequencer and the top-level PYNQ pin assignments.

## Interface
- `DW`, 8: bits per transfer.
- `CLK_DIV`, 4: system clocks per SCK half-period; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_send`  in  1  transfer request; level, held by the sender until `o_command_sent`.
- `i_data`  in  DW  byte to shift.
- `i_dc`  in  1  D/C value for this byte: 0 = command, 1 = data.
- `i_cs`  in  1  CS level to leave on the pin after the byte: 1 = release, 0 = keep selected.
- `o_command_sent`  out  1  one-cycle pulse at end of byte.
- `o_busy`  out  1  high from acceptance until return to IDLE.
- `o_sck`  out  1  panel SCK, idles low.
- `o_mosi`  out  1  panel SDI.
- `o_dc`  out  1  panel D/C.
- `o_cs`  out  1  panel CS, active-low.

## Operation
- All outputs are registered.
- Reset values: `o_sck`=0, `o_mosi`=0, `o_cs`=1, `o_dc`=1, `o_command_sent`=0, `o_busy`=0. Reset forces the FSM to IDLE and clears the counters.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE, REARM.
- **IDLE**:
  - On `i_send`=1, latch `i_data` into the shift register and latch `i_dc` and `i_cs`. Go to SETUP.
  - Otherwise the pins hold their last values; `o_cs` keeps the previous latched `i_cs`.
- **SETUP**:
  - `o_cs`=0, `o_dc`=latched dc, `o_mosi`=bit DW-1, `o_sck`=0, for CLK_DIV cycles.
  - Then go to SHIFT_HI.
- **SHIFT_HI**: `o_sck`=1 for CLK_DIV cycles; the panel samples on the rising edge. Then go to SHIFT_LO.
- **SHIFT_LO**:
  - `o_sck`=0 for CLK_DIV cycles.
  - On entry, shift left so `o_mosi` presents the next bit.
  - If the bit counter has not reached 0, decrement it and return to SHIFT_HI. Otherwise go to DONE.
  - The final low phase serves as CS hold time.
- **DONE**:
  - One cycle: `o_command_sent`=1 and `o_cs`=latched cs.
  - `o_mosi`=0. Go to REARM.
- **REARM**: wait for `i_send`=0, then go to IDLE. This prevents a held request from retriggering the same byte.
- Changes on `i_data`, `i_dc` or `i_cs` during a transfer are ignored.
- `i_send` deasserting mid-transfer does not abort; the byte completes and `o_command_sent` still pulses.
- `o_busy`=1 in every state except IDLE.

## Timing
- Acceptance edge E0 is the IDLE edge that samples `i_send`=1; `o_busy` rises in the cycle after E0.
- Byte length is (1 + 2·DW)·CLK_DIV cycles. With defaults: 17·4 = 68 cycles.
- `o_command_sent` is high exactly during cycle (1+2·DW)·CLK_DIV + 1 after E0 (cycle 69 with defaults).
- SCK period is 2·CLK_DIV clocks with 50 % duty and exactly DW rising edges per byte.
- MOSI is stable at least CLK_DIV clocks before and after each rising SCK edge.
- Minimum request-to-request spacing: one REARM cycle with `i_send`=0 plus one IDLE cycle. The sequencer's 8-cycle WAIT satisfies this.
- Counters:
  - Divider width is $clog2(CLK_DIV+1); it reloads CLK_DIV-1 on each phase entry.
  - Bit counter width is $clog2(DW); it loads DW-1 at acceptance.
  - No wrap-around occurs, because each counter is reloaded before it underflows.
- Asynchronous reset mid-byte: pins return to reset values immediately, with no `o_command_sent` pulse.
- When CLK_DIV=1, each phase lasts one cycle, giving byte length 17 cycles.

## Structure
- The package `pkg_ili9341` gains:
  - the `SPI_CLK_DIV` default;
  - a `spi_tx_state_t` enum;
  - reuse of the existing LOW/HIGH/NO_DATA constants.
- One sub-module, `spi_clk_phase`: the CLK_DIV phase counter, emitting a one-cycle `phase_end` strobe. It is enabled while the FSM is not in IDLE, DONE or REARM.
- The top-level connects the sequencer's `o_send`/`o_data`/`o_dc`/`o_cs` to `i_send`/`i_data`/`i_dc`/`i_cs`, and `o_command_sent` back to `i_command_sent`.

## Test plan
- **Single command.** Reset, then `i_send`=1 with `i_data`=0x2A, `i_dc`=0, `i_cs`=1, held until the pulse. Required:
  - MOSI sampled on 8 SCK rises reads 0,0,1,0,1,0,1,0.
  - `o_dc`=0 throughout; `o_cs` low for 68 cycles, then 1.
  - `o_command_sent` pulses once, in cycle 69.
- **Held request.** `i_send` kept at 1 for 200 cycles with `i_data`=0xFF. Required: exactly one byte and one pulse; the FSM stays in REARM until `i_send`=0.
- **Back-to-back data.** 0x00 then 0x80, both `i_dc`=1, `i_cs`=0, with 8 idle cycles between. Required:
  - `o_cs` stays 0 between bytes.
  - MOSI reads all zeros, then 1 followed by seven zeros.
  - Two pulses.
- **Input glitch.** `i_data` changed to 0x55 mid-byte and `i_send` dropped at cycle 10. Required: the original byte is shifted unchanged and the pulse still occurs.
- **Reset mid-byte.** Assert `rst` during SHIFT_HI of bit 4. Required:
  - Outputs take their reset values (`o_sck`=0, `o_mosi`=0, `o_cs`=1, `o_dc`=1, `o_command_sent`=0, `o_busy`=0) within the same cycle.
  - No pulse.
  - A fresh request after release transmits a full byte.
- **CLK_DIV=1.** Send 0xA5. Required: the byte takes 17 cycles, SCK toggles every cycle, and MOSI reads 1,0,1,0,0,1,0,1.
